// File: rtl/fetch_pkg.sv
// Shared types and decode helpers for the fetch stage: opcodes, FSM states,
// queue entry layout and RISC-V B/J immediate extraction.
package fetch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_DROP,
    ST_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        predTaken;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] immB(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] immJ(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched instructions. Clear wins over push/pop; push on a
// full queue and pop on an empty queue are ignored.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               clear,
  output logic [QW:0]        count,
  output logic [ENTRY_W-1:0] head,
  output logic               not_empty
);

  localparam logic [QW:0] FULL = (QW + 1)'(1 << QW);

  logic [ENTRY_W-1:0] mem_q [1 << QW];
  logic [QW-1:0]      head_q, head_d;
  logic [QW-1:0]      tail_q, tail_d;
  logic [QW:0]        count_q, count_d;
  logic               do_push, do_pop;

  assign do_push = push && (count_q != FULL);
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read once
  // count says it was written, so reset would just add fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[tail_q] <= push_data;
  end

  assign head      = mem_q[head_q];
  assign count     = count_q;
  assign not_empty = (count_q != '0);

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the PC, issues single outstanding icache requests, applies
// branch prediction and buffers results. FETCHER_JAL_REDIRECT_EN enables JAL redirect.
module instruction_fetcher
  import fetch_pkg::*;
#(
  parameter int          QUEUE_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clockIn,
  input  logic        resetIn,
  output logic        icacheReq,
  output logic [31:0] icacheAddr,
  input  logic        icacheValid,
  input  logic [31:0] icacheInstr,
  output logic [31:0] predAddr,
  output logic        predValid,
  input  logic        predJump,
  input  logic        flushValid,
  input  logic [31:0] flushPc,
  output logic        outValid,
  output logic [31:0] outInstr,
  output logic [31:0] outPc,
  output logic        outPredTaken,
  input  logic        outReady
);

  localparam logic [QUEUE_WIDTH:0] DEPTH = (QUEUE_WIDTH + 1)'(1 << QUEUE_WIDTH);

  fetch_state_e           state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            next_pc;
  logic                   pred_taken;
  logic                   is_jalr;
  logic                   q_push, q_clear, q_pop;
  logic [QUEUE_WIDTH:0]   q_count;
  logic [ENTRY_W-1:0]     q_head_bits;
  fetch_entry_t           q_in, q_head;

  always_comb begin
    next_pc    = pc_q + 32'd4;
    pred_taken = 1'b0;
    is_jalr    = 1'b0;
    unique case (icacheInstr[6:0])
      OP_BRANCH: begin
        pred_taken = predJump;
        if (predJump) next_pc = pc_q + immB(icacheInstr);
      end
`ifdef FETCHER_JAL_REDIRECT_EN
      OP_JAL: begin
        pred_taken = 1'b1;
        next_pc    = pc_q + immJ(icacheInstr);
      end
`endif
      OP_JALR: begin
        next_pc = pc_q;
        is_jalr = 1'b1;
      end
      default: ;
    endcase
  end

  // A flush overrides everything; a response still in flight must be dropped.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    icacheReq = 1'b0;
    q_push    = 1'b0;
    q_clear   = 1'b0;
    if (flushValid) begin
      q_clear = 1'b1;
      pc_d    = flushPc;
      state_d = (state_q == ST_WAIT && !icacheValid) ? ST_DROP : ST_FETCH;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (resetIn && q_count < DEPTH) begin
            icacheReq = 1'b1;
            state_d   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (icacheValid) begin
            q_push  = 1'b1;
            pc_d    = next_pc;
            state_d = is_jalr ? ST_HALT : ST_FETCH;
          end
        end
        ST_DROP: begin
          if (icacheValid) state_d = ST_FETCH;
        end
        ST_HALT: ;
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign q_in  = '{instr: icacheInstr, pc: pc_q, predTaken: pred_taken};
  assign q_pop = outValid && outReady;

  fetch_queue #(.QW(QUEUE_WIDTH)) u_queue (
    .clk       (clockIn),
    .rst_n     (resetIn),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .clear     (q_clear),
    .count     (q_count),
    .head      (q_head_bits),
    .not_empty (outValid)
  );

  assign q_head       = fetch_entry_t'(q_head_bits);
  assign outInstr     = q_head.instr;
  assign outPc        = q_head.pc;
  assign outPredTaken = q_head.predTaken;
  assign icacheAddr   = pc_q;
  assign predAddr     = pc_q;
  assign predValid    = icacheReq;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed scenarios plus a
// randomized run, checked every cycle against a queue-based reference model.
module tb_instruction_fetcher;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] ADDI     = 32'h00100093;
  localparam logic [31:0] BEQ_M8   = 32'hFE000CE3;
  localparam logic [31:0] JALR     = 32'h00008067;
  localparam logic [31:0] JAL_P20  = 32'h0200006F;

  logic        clockIn, resetIn;
  logic        icacheReq, icacheValid, predValid, predJump;
  logic [31:0] icacheAddr, icacheInstr, predAddr, flushPc;
  logic        flushValid, outValid, outPredTaken, outReady;
  logic [31:0] outInstr, outPc;

  instruction_fetcher #(.QUEUE_WIDTH(2), .RESET_PC(RESET_PC)) dut (
    .clockIn      (clockIn),
    .resetIn      (resetIn),
    .icacheReq    (icacheReq),
    .icacheAddr   (icacheAddr),
    .icacheValid  (icacheValid),
    .icacheInstr  (icacheInstr),
    .predAddr     (predAddr),
    .predValid    (predValid),
    .predJump     (predJump),
    .flushValid   (flushValid),
    .flushPc      (flushPc),
    .outValid     (outValid),
    .outInstr     (outInstr),
    .outPc        (outPc),
    .outPredTaken (outPredTaken),
    .outReady     (outReady)
  );

  initial clockIn = 1'b0;
  always #5 clockIn = ~clockIn;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          taken;
  } ent_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: program image, expected PC, decoded-instruction queue,
  // and the single in-flight icache request (also the bench's icache).
  logic [31:0] prog [logic [31:0]];
  logic [31:0] m_pc;
  ent_t        m_q[$];
  bit          m_out, m_drop, m_halt;
  int          m_cnt;
  logic [31:0] m_addr;

  int          lat_fix = 1;
  bit          drv_pred, drv_ready;
  bit          last_req_valid;
  logic [31:0] last_req_addr;
  int          req_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 99);
    if (r < 55)      w[6:0] = 7'b0010011;
    else if (r < 75) w[6:0] = 7'b1100011;
    else if (r < 85) w[6:0] = 7'b1101111;
    else if (r < 90) w[6:0] = 7'b1100111;
    else if (w[6:0] == 7'b1100011 || w[6:0] == 7'b1101111 || w[6:0] == 7'b1100111)
      w[6:0] = 7'b0110011;
    return w;
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] addr);
    if (!prog.exists(addr)) prog[addr] = rand_instr();
    return prog[addr];
  endfunction

  function automatic int b_off(input logic [31:0] i);
    logic signed [12:0] v;
    int s;
    v = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    s = v;
    return s;
  endfunction

  function automatic int j_off(input logic [31:0] i);
    logic signed [20:0] v;
    int s;
    v = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    s = v;
    return s;
  endfunction

  function automatic void decode(input logic [31:0] instr, input logic [31:0] pc, input bit pred,
                                 output logic [31:0] npc, output bit taken, output bit halt);
    npc   = pc + 32'd4;
    taken = 1'b0;
    halt  = 1'b0;
    case (instr[6:0])
      7'b1100011: begin
        taken = pred;
        if (pred) npc = pc + b_off(instr);
      end
      7'b1101111: begin
`ifdef FETCHER_JAL_REDIRECT_EN
        taken = 1'b1;
        npc   = pc + j_off(instr);
`endif
      end
      7'b1100111: begin
        npc  = pc;
        halt = 1'b1;
      end
      default: ;
    endcase
  endfunction

  // One clock cycle: drive at negedge, check outputs, advance the model, wait.
  task automatic step(input bit flush, input logic [31:0] fpc);
    bit          resp, exp_req, taken, halt;
    logic [31:0] rinstr, npc;
    resp   = m_out && (m_cnt == 1);
    rinstr = resp ? fetch_word(m_addr) : $urandom;
    icacheValid = resp;
    icacheInstr = rinstr;
    predJump    = drv_pred;
    flushValid  = flush;
    flushPc     = fpc;
    outReady    = drv_ready;
    #1;
    exp_req = !m_halt && !m_out && (m_q.size() < DEPTH) && !flush;
    check("icacheReq", icacheReq, exp_req);
    check("predValid", predValid, exp_req);
    check("icacheAddr", icacheAddr, m_pc);
    check("predAddr", predAddr, m_pc);
    check("outValid", outValid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("outInstr", outInstr, m_q[0].instr);
      check("outPc", outPc, m_q[0].pc);
      check("outPredTaken", outPredTaken, m_q[0].taken);
    end
    last_req_valid = (icacheReq === 1'b1);
    last_req_addr  = icacheAddr;
    if (last_req_valid) req_cnt++;

    if (flush) begin
      m_q.delete();
      if (m_out && !resp) begin
        m_drop = 1'b1;
        m_cnt--;
      end else begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      m_pc   = fpc;
      m_halt = 1'b0;
    end else begin
      if (drv_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (resp) begin
        m_out = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else begin
          decode(rinstr, m_pc, drv_pred, npc, taken, halt);
          m_q.push_back('{instr: rinstr, pc: m_pc, taken: taken});
          m_pc   = npc;
          m_halt = halt;
        end
      end else if (m_out) m_cnt--;
      if (exp_req) begin
        m_out  = 1'b1;
        m_addr = m_pc;
        m_cnt  = (lat_fix != 0) ? lat_fix : $urandom_range(1, 3);
      end
    end
    @(posedge clockIn);
    @(negedge clockIn);
  endtask

  task automatic run_until_req(input int budget, output logic [31:0] addr, output int n);
    addr = 32'hFFFF_FFFF;
    n    = 0;
    for (int k = 0; k < budget; k++) begin
      step(1'b0, 32'h0);
      n++;
      if (last_req_valid) begin
        addr = last_req_addr;
        return;
      end
    end
  endtask

  task automatic do_reset();
    resetIn     = 1'b0;
    icacheValid = 1'b0;
    icacheInstr = '0;
    flushValid  = 1'b0;
    flushPc     = '0;
    outReady    = 1'b0;
    predJump    = 1'b0;
    repeat (2) begin
      #1;
      check("rst_icacheReq", icacheReq, 1'b0);
      check("rst_outValid", outValid, 1'b0);
      check("rst_pc", icacheAddr, RESET_PC);
      @(posedge clockIn);
      @(negedge clockIn);
    end
    m_pc   = RESET_PC;
    m_q.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_halt = 1'b0;
    m_cnt  = 0;
    resetIn = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    int          n, base;
    resetIn = 1'b0;
    @(negedge clockIn);
    do_reset();

    // Sequential fetch from reset with latency 1.
    prog[32'h0] = ADDI;
    prog[32'h4] = ADDI;
    drv_ready = 1'b0;
    drv_pred  = 1'b0;
    lat_fix   = 1;
    run_until_req(10, a, n); check("t1_req0", a, 32'h0);
    run_until_req(10, a, n); check("t1_req1", a, 32'h4);
    run_until_req(10, a, n); check("t1_req2", a, 32'h8);
    check("t1_head_pc", outPc, 32'h0);
    check("t1_head_taken", outPredTaken, 1'b0);

    // Predicted-taken and not-taken BEQ at 0x10 with immB = -8.
    prog[32'h10] = BEQ_M8;
    prog[32'h8]  = ADDI;
    drv_pred = 1'b1;
    step(1'b1, 32'h10);
    run_until_req(10, a, n); check("t2_req_beq", a, 32'h10);
    run_until_req(10, a, n); check("t2_taken_tgt", a, 32'h8);
    check("t2_taken_pc", outPc, 32'h10);
    check("t2_taken_bit", outPredTaken, 1'b1);
    drv_pred = 1'b0;
    step(1'b1, 32'h10);
    run_until_req(10, a, n); check("t2_req_beq2", a, 32'h10);
    run_until_req(10, a, n); check("t2_ntaken_tgt", a, 32'h14);
    check("t2_ntaken_bit", outPredTaken, 1'b0);

    // Backpressure: four fills stop requests; one pop allows exactly one more.
    for (int k = 0; k < 6; k++) prog[32'h200 + 4 * k] = ADDI;
    step(1'b1, 32'h200);
    base = req_cnt;
    repeat (20) step(1'b0, 32'h0);
    check("t3_reqs_full", req_cnt - base, 4);
    check("t3_full_valid", outValid, 1'b1);
    drv_ready = 1'b1;
    step(1'b0, 32'h0);
    drv_ready = 1'b0;
    base = req_cnt;
    repeat (15) step(1'b0, 32'h0);
    check("t3_reqs_after_pop", req_cnt - base, 1);

    // Flush while waiting; the late response is dropped.
    prog[32'h300] = ADDI;
    prog[32'h100] = ADDI;
    step(1'b1, 32'h300);
    lat_fix = 3;
    run_until_req(10, a, n); check("t4_req", a, 32'h300);
    lat_fix = 1;
    step(1'b1, 32'h100);
    run_until_req(10, a, n); check("t4_redirect", a, 32'h100);
    check("t4_gap", n, 3);
    check("t4_dropped", outValid, 1'b0);

    // JALR halts fetching until a flush.
    prog[32'h20] = JALR;
    step(1'b1, 32'h20);
    run_until_req(10, a, n); check("t5_req_jalr", a, 32'h20);
    base = req_cnt;
    repeat (10) step(1'b0, 32'h0);
    check("t5_halted", req_cnt - base, 0);
    check("t5_jalr_pc", outPc, 32'h20);
    check("t5_jalr_taken", outPredTaken, 1'b0);
    step(1'b1, 32'h40);
    run_until_req(10, a, n); check("t5_restart", a, 32'h40);
    check("t5_restart_gap", n, 1);

    // JAL at 0x30 with immJ = +0x20.
    prog[32'h30] = JAL_P20;
    step(1'b1, 32'h30);
    run_until_req(10, a, n); check("t6_req_jal", a, 32'h30);
    run_until_req(10, a, n);
`ifdef FETCHER_JAL_REDIRECT_EN
    check("t6_jal_next", a, 32'h50);
    check("t6_jal_taken", outPredTaken, 1'b1);
`else
    check("t6_jal_next", a, 32'h34);
    check("t6_jal_taken", outPredTaken, 1'b0);
`endif

    // Randomized traffic with a mid-run reset.
    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          fl;
      logic [31:0] fpc;
      if (i == 1500) do_reset();
      drv_pred  = $urandom_range(0, 1);
      drv_ready = ($urandom_range(0, 99) < 60);
      fl  = !m_drop && ($urandom_range(0, 99) < (m_halt ? 30 : 4));
      fpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      step(fl, fpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Fetch stage that owns the program counter, issues one-at-a-time requests to the instruction cache, and consults the branch predictor for conditional branches. It computes the next PC from the fetched instruction and the predictor's `jump` bit, then buffers fetched instructions in a small queue for the decoder. A flush from the Reorder Buffer redirects it after a misprediction. It sits between icache/predictor and the decoder.

## Interface
- `QUEUE_WIDTH`, 2: log2 of fetch-queue depth (depth 4).
- `RESET_PC`, 32'h0: PC after reset.

Ports:
- `clockIn` in 1: clock. One clock domain.
- `resetIn` in 1: reset, asynchronous, active-low.
- `icacheReq` out 1: request strobe, one cycle per fetch.
- `icacheAddr` out 32: fetch address; equals PC register.
- `icacheValid` in 1: response valid.
- `icacheInstr` in 32: response instruction.
- `predAddr` out 32: address to predictor; equals PC register (held during wait).
- `predValid` out 1: equals `icacheReq`.
- `predJump` in 1: predictor taken bit for `predAddr` sampled the previous edge.
- `flushValid` in 1: ROB redirect.
- `flushPc` in 32: redirect target.
- `outValid` out 1: queue head valid.
- `outInstr` out 32, `outPc` out 32, `outPredTaken` out 1: head entry.
- `outReady` in 1: decoder accepts head.

## Operation
- State machine: FETCH, WAIT, DROP, HALT.
  - FETCH: `icacheReq`=1 iff count < depth and no flush; on request -> WAIT.
  - WAIT: on `icacheValid`, push {instr, pc, taken}, update PC. Go to HALT if the instruction is JALR, else FETCH.
  - DROP: discard the pending response. On `icacheValid` -> FETCH.
  - HALT: no requests. Leaves only on flush.
- Next PC by opcode (`icacheInstr[6:0]`):
  - 1100011 (branch): `predJump` ? PC+immB : PC+4; `outPredTaken`=`predJump`.
  - 1101111 (JAL): see Configuration.
  - 1100111 (JALR): PC unchanged, state -> HALT, `outPredTaken`=0.
  - Other opcodes: PC+4, `outPredTaken`=0.
- Immediates are sign-extended to 32 bits. Additions are 32-bit with wrap-around and no trap.
- Queue: circular, depth 2^QUEUE_WIDTH. Head/tail pointers are QUEUE_WIDTH bits; count is QUEUE_WIDTH+1 bits.
  - Pop on `outValid && outReady`.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow cannot occur: a request is issued only when count < depth, and only one request is outstanding.
- Flush has highest priority:
  - Queue cleared, ignoring any same-cycle pop or push. PC <= `flushPc`.
  - State -> DROP if in WAIT with no same-cycle `icacheValid`, else FETCH.
  - A response that arrives in the flush cycle is discarded.

## Timing
- Reset values: PC=`RESET_PC`, state FETCH, count/pointers 0, `outValid`=0, `icacheReq`=0 while `resetIn` low.
- First `icacheReq` is in the first cycle after `resetIn` rises.
- icache latency is ≥1 cycle. PC is held from request through response, so `predJump` is valid when `icacheValid` arrives.
- Push is at the response edge; `outValid` is high the next cycle. Peak throughput is one instruction per (latency+1) cycles.
- First request to `flushPc` issues the cycle after flush, or the cycle after the discarded response when in DROP.
- Reset mid-WAIT: state returns to FETCH immediately. The icache is reset by the same signal.

## Configuration
- `FETCHER_JAL_REDIRECT_EN`:
  - Defined: JAL sets next PC = PC+immJ and `outPredTaken`=1.
  - Undefined: JAL is treated as sequential (PC+4, `outPredTaken`=0) and the ROB corrects it via flush.

## Structure
- Shared package `fetch_pkg`:
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - State enum.
  - Functions immB and immJ.
  - Queue entry struct {instr, pc, predTaken}.
- Sub-module `fetch_queue`: parameterised circular FIFO with push, pop, clear, count and head outputs. Next-PC logic and the FSM stay in the top.

## Test plan
- Reset release, icache latency 1, instrs ADDI at 0x0 and 0x4 -> requests at 0x0, 0x4, 0x8. Queue entries carry PCs 0x0 and 0x4 with `outPredTaken`=0.
- BEQ at 0x10 with immB=-8, `predJump`=1 -> next request at 0x08, entry `outPredTaken`=1. With `predJump`=0 -> next request at 0x14.
- `outReady`=0 while fetching 4 ADDIs -> `icacheReq` stays 0 with count=4. One pop -> exactly one new request.
- Flush to 0x100 while in WAIT, response arriving 2 cycles later -> response dropped, queue empty, next request at 0x100.
- JALR at 0x20 -> entry pushed, no further requests. Flush to 0x40 -> request at 0x40 the next cycle.
- JAL at 0x30 with immJ=+0x20 -> next request at 0x50 with macro defined, 0x34 without.
